updn_counter_param: RTL and testbench

Parametrised successor to the team's fixed 16-bit up/down counter. Adds:
- configurable width;
- run-time modulus (upper limit);
- variable step size;
- selectable wrap or saturate mode;
- sticky overflow/underflow flags and a terminal-count indicator.

It keeps the same load/enable/direction control semantics as the existing counter, so it drops into the same datapath sockets and the same assertion-based bench.

---
 rtl/updn_counter_param.sv | 92 +++++++++
 tb/tb_updn_counter_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with run-time upper limit, variable step,
// wrap or saturate behaviour at the limits, sticky overflow/underflow flags
// and a combinational terminal-count output.
module updn_counter_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic [STEP_W-1:0] step,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned XW  = WIDTH + 1;
  localparam bit          Sat = (SAT_MODE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_set, unf_set;

  // One extra bit so sums and wrap corrections never lose a carry.
  logic [XW-1:0] cur_x, lim_x, lim_p1, step_x, up_sum;

  assign cur_x  = {1'b0, count_q};
  assign lim_x  = {1'b0, hi_lim};
  assign lim_p1 = lim_x + XW'(1);
  assign step_x = XW'(step);
  assign up_sum = cur_x + step_x;

  // Next-state selection: load beats count beats hold.
  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!ld_cnt) begin
      count_d = (data_in > hi_lim) ? hi_lim : data_in;
    end else if (count_enb && (step != '0)) begin
      if (cur_x > lim_x) begin
        // Limit was lowered under the current value: pull back to the limit.
        count_d = hi_lim;
        ovf_set = 1'b1;
      end else if (updn_cnt) begin
        if (up_sum <= lim_x) begin
          count_d = WIDTH'(up_sum);
        end else begin
          ovf_set = 1'b1;
          count_d = Sat ? hi_lim : WIDTH'(up_sum - lim_p1);
        end
      end else begin
        if (step_x <= cur_x) begin
          count_d = WIDTH'(cur_x - step_x);
        end else begin
          unf_set = 1'b1;
          count_d = Sat ? '0 : WIDTH'(cur_x + lim_p1 - step_x);
        end
      end
    end
    // A new crossing in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    unf_d = unf_set | (unf_q & ~clr_flags);
  end

  // Count and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign data_out = count_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign tc       = updn_cnt ? (count_q == hi_lim) : (count_q == '0);

endmodule

// File: tb/tb_updn_counter_param.sv
// Bench for updn_counter_param: drives a wrap-mode and a saturate-mode
// instance with the same directed stimulus and checks both every cycle
// against an arithmetic model, plus hand-computed expectations.
module tb_updn_counter_param;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic [W-1:0]  data_in, hi_lim;
  logic [SW-1:0] step;
  logic          ld_cnt, updn_cnt, count_enb, clr_flags;

  logic [W-1:0] dout [2];
  logic         tc_o [2];
  logic         ovf_o [2];
  logic         unf_o [2];

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  updn_counter_param #(.WIDTH(W), .STEP_W(SW), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst_(rst_), .data_in(data_in), .hi_lim(hi_lim), .step(step),
    .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb), .clr_flags(clr_flags),
    .data_out(dout[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0])
  );

  updn_counter_param #(.WIDTH(W), .STEP_W(SW), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst_(rst_), .data_in(data_in), .hi_lim(hi_lim), .step(step),
    .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb), .clr_flags(clr_flags),
    .data_out(dout[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1])
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = wrap instance, 1 = saturate instance.
  longint m_cnt [2];
  bit     m_ovf [2];
  bit     m_unf [2];

  function automatic bit counting();
    return ld_cnt && count_enb && (step != 0);
  endfunction

  function automatic longint nxt_cnt(input bit sat, input longint c);
    longint lim, st, din;
    lim = longint'(hi_lim);
    st  = longint'(step);
    din = longint'(data_in);
    if (!ld_cnt) return (din > lim) ? lim : din;
    if (!counting()) return c;
    if (c > lim) return lim;
    if (updn_cnt) begin
      if (c + st <= lim) return c + st;
      return sat ? lim : (c + st) % (lim + 1);
    end
    if (st <= c) return c - st;
    return sat ? 0 : (c - st + lim + 1) % (lim + 1);
  endfunction

  function automatic bit ovf_hit(input longint c);
    longint lim;
    lim = longint'(hi_lim);
    return counting() && ((c > lim) || (updn_cnt && (c + longint'(step) > lim)));
  endfunction

  function automatic bit unf_hit(input longint c);
    longint lim;
    lim = longint'(hi_lim);
    return counting() && (c <= lim) && !updn_cnt && (longint'(step) > c);
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_cnt[0] <= 0; m_ovf[0] <= 1'b0; m_unf[0] <= 1'b0;
      m_cnt[1] <= 0; m_ovf[1] <= 1'b0; m_unf[1] <= 1'b0;
    end else begin
      m_cnt[0] <= nxt_cnt(1'b0, m_cnt[0]);
      m_ovf[0] <= ovf_hit(m_cnt[0]) || (m_ovf[0] && !clr_flags);
      m_unf[0] <= unf_hit(m_cnt[0]) || (m_unf[0] && !clr_flags);
      m_cnt[1] <= nxt_cnt(1'b1, m_cnt[1]);
      m_ovf[1] <= ovf_hit(m_cnt[1]) || (m_ovf[1] && !clr_flags);
      m_unf[1] <= unf_hit(m_cnt[1]) || (m_unf[1] && !clr_flags);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model data_out[%0d]", i), longint'(dout[i]), m_cnt[i]);
        chk($sformatf("model ovf[%0d]", i), longint'(ovf_o[i]), longint'(m_ovf[i]));
        chk($sformatf("model unf[%0d]", i), longint'(unf_o[i]), longint'(m_unf[i]));
        chk($sformatf("model tc[%0d]", i), longint'(tc_o[i]),
            updn_cnt ? longint'(m_cnt[i] == longint'(hi_lim)) : longint'(m_cnt[i] == 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    data_in = '0; hi_lim = '1; step = '0;
    ld_cnt = 1'b1; updn_cnt = 1'b1; count_enb = 1'b0; clr_flags = 1'b0;
    #1 rst_ = 1'b0;
    cmp_on = 1'b1;
    tick(); tick();
    rst_ = 1'b1;
    tick();
    chk("reset data_out", longint'(dout[0]), 0);

    // Reset asserted between edges clears outputs without a clock.
    data_in = 16'h1234; ld_cnt = 1'b0; tick(); ld_cnt = 1'b1;
    chk("preload 1234", longint'(dout[0]), 16'h1234);
    #2 rst_ = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async reset data_out[%0d]", i), longint'(dout[i]), 0);
      chk($sformatf("async reset ovf[%0d]", i), longint'(ovf_o[i]), 0);
      chk($sformatf("async reset unf[%0d]", i), longint'(unf_o[i]), 0);
    end
    tick(); rst_ = 1'b1; tick(); tick();
    chk("hold after release", longint'(dout[0]), 0);

    // Wrap up: 7 -> 9 -> 1 -> 3 with hi_lim 9, step 2.
    hi_lim = 16'd9; data_in = 16'd7; step = 4'd2; updn_cnt = 1'b1;
    ld_cnt = 1'b0; count_enb = 1'b1; tick(); ld_cnt = 1'b1;
    chk("wrap load 7", longint'(dout[0]), 7);
    tick();
    chk("wrap up 9", longint'(dout[0]), 9);
    chk("wrap tc at 9", longint'(tc_o[0]), 1);
    chk("wrap ovf before cross", longint'(ovf_o[0]), 0);
    tick();
    chk("wrap up 1", longint'(dout[0]), 1);
    chk("wrap ovf after cross", longint'(ovf_o[0]), 1);
    tick();
    chk("wrap up 3", longint'(dout[0]), 3);
    chk("sat pinned at 9", longint'(dout[1]), 9);
    count_enb = 1'b0;

    // Wrap down and flag clear behaviour.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    data_in = 16'd1; ld_cnt = 1'b0; tick(); ld_cnt = 1'b1;
    updn_cnt = 1'b0; step = 4'd3; count_enb = 1'b1; tick();
    chk("wrap down 8", longint'(dout[0]), 8);
    chk("wrap unf set", longint'(unf_o[0]), 1);
    tick();
    chk("wrap down 5", longint'(dout[0]), 5);
    clr_flags = 1'b1; tick();
    chk("wrap down 2", longint'(dout[0]), 2);
    chk("unf cleared", longint'(unf_o[0]), 0);
    tick();
    chk("wrap down 9", longint'(dout[0]), 9);
    chk("set beats clear", longint'(unf_o[0]), 1);
    clr_flags = 1'b0; count_enb = 1'b0;

    // Saturate at hi_lim 0xFF, then at 0.
    hi_lim = 16'h00FF; data_in = 16'h00FE; ld_cnt = 1'b0; clr_flags = 1'b1; tick();
    ld_cnt = 1'b1; clr_flags = 1'b0;
    step = 4'd4; updn_cnt = 1'b1; count_enb = 1'b1; tick();
    chk("sat up FF", longint'(dout[1]), 16'h00FF);
    chk("sat ovf", longint'(ovf_o[1]), 1);
    chk("wrap FE+4", longint'(dout[0]), 2);
    tick();
    chk("sat stays FF", longint'(dout[1]), 16'h00FF);
    count_enb = 1'b0; data_in = 16'd2; ld_cnt = 1'b0; tick(); ld_cnt = 1'b1;
    step = 4'd5; updn_cnt = 1'b0; count_enb = 1'b1; tick();
    chk("sat down 0", longint'(dout[1]), 0);
    chk("sat unf", longint'(unf_o[1]), 1);
    chk("wrap 2-5", longint'(dout[0]), 16'h00FD);
    count_enb = 1'b0;

    // Load wins over count and is clamped; lowered limit forces ovf.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    hi_lim = 16'd100; data_in = 16'd200; ld_cnt = 1'b0; count_enb = 1'b1;
    updn_cnt = 1'b1; step = 4'd1; tick();
    ld_cnt = 1'b1; count_enb = 1'b0;
    chk("clamped load", longint'(dout[0]), 100);
    chk("load leaves ovf", longint'(ovf_o[0]), 0);
    hi_lim = 16'd50; updn_cnt = 1'b0; count_enb = 1'b1; tick();
    chk("out of range pulled to 50", longint'(dout[0]), 50);
    chk("out of range ovf", longint'(ovf_o[1]), 1);
    count_enb = 1'b0;

    // hi_lim = 0 keeps the counter at 0.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    hi_lim = 16'd0; data_in = 16'd5; ld_cnt = 1'b0; tick(); ld_cnt = 1'b1;
    updn_cnt = 1'b1; step = 4'd1; count_enb = 1'b1; tick();
    chk("zero lim up", longint'(dout[0]), 0);
    chk("zero lim ovf", longint'(ovf_o[0]), 1);
    updn_cnt = 1'b0; tick();
    chk("zero lim unf", longint'(unf_o[1]), 1);
    count_enb = 1'b0;

    // Hold, step 0, and carry past the full-width limit.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    hi_lim = 16'hFFFF; data_in = 16'h8000; ld_cnt = 1'b0; tick(); ld_cnt = 1'b1;
    repeat (5) tick();
    chk("hold 8000", longint'(dout[0]), 16'h8000);
    count_enb = 1'b1; step = 4'd0; updn_cnt = 1'b1; tick();
    chk("step 0 hold", longint'(dout[1]), 16'h8000);
    chk("step 0 no ovf", longint'(ovf_o[0]), 0);
    count_enb = 1'b0; data_in = 16'hFFF8; ld_cnt = 1'b0; tick(); ld_cnt = 1'b1;
    step = 4'd15; count_enb = 1'b1; tick();
    chk("wrap full width 7", longint'(dout[0]), 7);
    chk("full width ovf", longint'(ovf_o[0]), 1);
    chk("sat full width", longint'(dout[1]), 16'hFFFF);
    count_enb = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
